// File: rtl/axil_cmd_master.sv
// AXI4-Lite master that executes one single-beat write or read per command and holds the result until consumed.
// Optional watchdog abort is compiled in with AXIL_CMD_MASTER_TIMEOUT_EN.
module axil_cmd_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              axi_clk,
  input  logic              axi_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [2:0]        m_awprot,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arprot,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
);

  typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  logic [15:0] wd;
`else
  assign rsp_timeout = 1'b0;
`endif

  // One latched address serves both channels; only one transaction is ever in flight.
  assign m_awaddr = addr_q;
  assign m_araddr = addr_q;
  assign m_awprot = 3'b000;
  assign m_arprot = 3'b000;

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      addr_q    <= '0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
      wr_count  <= '0;
      rd_count  <= '0;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      wd          <= '0;
      rsp_timeout <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            m_wdata   <= cmd_wdata;
            m_wstrb   <= cmd_wstrb;
            if (cmd_write) begin
              state     <= WR;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
            end else begin
              state     <= RA;
              m_arvalid <= 1'b1;
            end
          end
        end
        WR: begin
          // A channel whose valid is already low has completed its handshake.
          if (m_awready) m_awvalid <= 1'b0;
          if (m_wready)  m_wvalid  <= 1'b0;
          if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
            state    <= WB;
            m_bready <= 1'b1;
          end
        end
        WB: begin
          if (m_bvalid) begin
            m_bready  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= m_bresp;
            wr_count  <= wr_count + 16'd1;
            state     <= RSP;
          end
        end
        RA: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= RD;
          end
        end
        RD: begin
          if (m_rvalid) begin
            m_rready  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= m_rdata;
            rsp_resp  <= m_rresp;
            rd_count  <= rd_count + 16'd1;
            state     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      if (state == IDLE && cmd_valid && cmd_ready) begin
        wd          <= '0;
        rsp_timeout <= 1'b0;
      end else if (state == WR || state == WB || state == RA || state == RD) begin
        if (wd == 16'(TIMEOUT_CYCLES - 1)) begin
          // Abort overrides any handshake this cycle; valids drop without completing.
          m_awvalid   <= 1'b0;
          m_wvalid    <= 1'b0;
          m_bready    <= 1'b0;
          m_arvalid   <= 1'b0;
          m_rready    <= 1'b0;
          rsp_valid   <= 1'b1;
          rsp_rdata   <= '0;
          rsp_resp    <= 2'b11;
          rsp_timeout <= 1'b1;
          wr_count    <= wr_count;
          rd_count    <= rd_count;
          state       <= RSP;
        end else begin
          wd <= wd + 16'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Randomized bench for axil_cmd_master: transaction-level model checked every cycle plus literal pins.
module tb_axil_cmd_master;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 256;
`endif

  logic        axi_clk, axi_rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic [15:0] wr_count, rd_count;

  axil_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Slave behaviour knobs, set by the stimulus before each command.
  int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0]  nx_bresp, nx_rresp;
  logic [31:0] nx_rdata;

  task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  initial begin : slave
    int aw_c, w_c, b_c, ar_c, r_c;
    bit aw_got, w_got, ar_got, p_aw, p_w, p_b, p_ar, p_r;
    {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '0;
    m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
    {aw_c, w_c, b_c, ar_c, r_c} = '0;
    {aw_got, w_got, ar_got, p_aw, p_w, p_b, p_ar, p_r} = '0;
    forever begin
      @(posedge axi_clk); #1;
      if (axi_rst) begin
        {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '0;
        {aw_c, w_c, b_c, ar_c, r_c} = '0;
        {aw_got, w_got, ar_got, p_aw, p_w, p_b, p_ar, p_r} = '0;
      end else begin
        if (p_aw) aw_got = 1;
        if (p_w)  w_got  = 1;
        if (p_b)  begin m_bvalid = 0; aw_got = 0; w_got = 0; b_c = 0; end
        if (p_ar) ar_got = 1;
        if (p_r)  begin m_rvalid = 0; ar_got = 0; r_c = 0; end
        if (m_awvalid) begin m_awready = (aw_c >= aw_dly); aw_c++; end else begin m_awready = 0; aw_c = 0; end
        if (m_wvalid)  begin m_wready  = (w_c >= w_dly);   w_c++;  end else begin m_wready  = 0; w_c  = 0; end
        if (m_arvalid) begin m_arready = (ar_c >= ar_dly); ar_c++; end else begin m_arready = 0; ar_c = 0; end
        if (aw_got && w_got && !m_bvalid) begin
          if (b_c >= b_dly) begin m_bvalid = 1; m_bresp = nx_bresp; end else b_c++;
        end
        if (ar_got && !m_rvalid) begin
          if (r_c >= r_dly) begin m_rvalid = 1; m_rresp = nx_rresp; m_rdata = nx_rdata; end else r_c++;
        end
        p_aw = m_awvalid && m_awready;
        p_w  = m_wvalid && m_wready;
        p_b  = m_bvalid && m_bready;
        p_ar = m_arvalid && m_arready;
        p_r  = m_rvalid && m_rready;
      end
    end
  end

  // Transaction-level model: outstanding obligations of the current command.
  bit          started, busy, aw_p, w_p, b_p, ar_p, r_p, rsp_p, e_to, prev_rv;
  logic [31:0] c_addr, c_data, e_rdata;
  logic [3:0]  c_strb;
  logic [1:0]  e_resp;
  logic [15:0] wr_n, rd_n;
  int          wd, cyc, acc_cyc, rsp_cyc, n_aw, n_w, n_ar, n_crdy;

  initial begin
    {started, busy, aw_p, w_p, b_p, ar_p, r_p, rsp_p, e_to, prev_rv} = '0;
    wr_n = 0; rd_n = 0; wd = 0; cyc = 0; acc_cyc = 0; rsp_cyc = 0;
    n_aw = 0; n_w = 0; n_ar = 0; n_crdy = 0;
  end

  always @(negedge axi_clk) begin : compare
    bit abort;
    cyc++;
    if (m_awvalid === 1'b1) n_aw++;
    if (m_wvalid === 1'b1)  n_w++;
    if (m_arvalid === 1'b1) n_ar++;
    if (cmd_ready === 1'b1) n_crdy++;
    if (rsp_valid === 1'b1 && !prev_rv) rsp_cyc = cyc;
    prev_rv = (rsp_valid === 1'b1);
    if (axi_rst) begin
      chk("rst_ctl", {cmd_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_timeout}, 0);
      chk("rst_cnt", {wr_count, rd_count}, 0);
      chk("rst_dat", {m_awaddr, m_wdata}, 0);
      chk("rst_rsp", {rsp_rdata, rsp_resp, m_wstrb}, 0);
      {started, busy, aw_p, w_p, b_p, ar_p, r_p, rsp_p, e_to} = '0;
      wr_n = 0; rd_n = 0; wd = 0;
    end else begin
      chk("cmd_ready", cmd_ready, started && !busy);
      chk("awvalid", m_awvalid, aw_p);
      chk("wvalid", m_wvalid, w_p);
      chk("bready", m_bready, b_p);
      chk("arvalid", m_arvalid, ar_p);
      chk("rready", m_rready, r_p);
      chk("rsp_valid", rsp_valid, rsp_p);
      chk("wr_count", wr_count, wr_n);
      chk("rd_count", rd_count, rd_n);
      chk("prot", {m_awprot, m_arprot}, 0);
      if (aw_p) chk("awaddr", m_awaddr, c_addr);
      if (w_p)  chk("wdata", {m_wdata, m_wstrb}, {c_data, c_strb});
      if (ar_p) chk("araddr", m_araddr, c_addr);
      if (rsp_p) chk("rsp_payload", {rsp_rdata, rsp_resp, rsp_timeout}, {e_rdata, e_resp, e_to});

      if (!busy) begin
        if (started && cmd_valid) begin
          busy = 1; c_addr = cmd_addr; c_data = cmd_wdata; c_strb = cmd_wstrb;
          wd = 0; acc_cyc = cyc;
          if (cmd_write) begin aw_p = 1; w_p = 1; end else ar_p = 1;
        end
      end else if (rsp_p) begin
        if (rsp_ready) begin rsp_p = 0; busy = 0; end
      end else begin
        abort = 0;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
        abort = (wd == TO - 1);
        wd++;
`endif
        if (abort) begin
          {aw_p, w_p, b_p, ar_p, r_p} = '0;
          rsp_p = 1; e_rdata = 0; e_resp = 2'b11; e_to = 1;
        end else if (aw_p || w_p) begin
          if (aw_p && m_awready) aw_p = 0;
          if (w_p && m_wready)   w_p  = 0;
          if (!aw_p && !w_p)     b_p  = 1;
        end else if (b_p) begin
          if (m_bvalid) begin b_p = 0; rsp_p = 1; e_rdata = 0; e_resp = m_bresp; e_to = 0; wr_n++; end
        end else if (ar_p) begin
          if (m_arready) begin ar_p = 0; r_p = 1; end
        end else if (r_p) begin
          if (m_rvalid) begin r_p = 0; rsp_p = 1; e_rdata = m_rdata; e_resp = m_rresp; e_to = 0; rd_n++; end
        end
      end
      started = 1;
    end
  end

  logic [31:0] l_rdata;
  logic [1:0]  l_resp;
  logic        l_to;

  task automatic send(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge axi_clk);
      ok = (cmd_ready === 1'b1);
      @(posedge axi_clk); #1;
    end
    cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    if (!ok) note_fail("cmd_accept");
  endtask

  task automatic recv(input bit rnd);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge axi_clk);
      if (rsp_valid === 1'b1 && rsp_ready) begin
        done = 1; l_rdata = rsp_rdata; l_resp = rsp_resp; l_to = rsp_timeout;
      end
      @(posedge axi_clk); #1;
    end
    rsp_ready = 0;
    if (!done) note_fail("rsp_wait");
  endtask

  initial begin : main
    int b_aw, b_w, b_ar, b_cr;
    bit seen;
    axi_rst = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    nx_bresp = 0; nx_rresp = 0; nx_rdata = 0;
    set_dly(0, 0, 0, 0, 0);
    #1 axi_rst = 1;
    repeat (3) @(posedge axi_clk);
    #2 axi_rst = 0;
    @(posedge axi_clk); #1;

    // Write, slave always ready.
    b_aw = n_aw;
    send(1, 32'd3, 32'hDEADBEEF, 4'hF);
    recv(0);
    chk("w1_aw_cycles", n_aw - b_aw, 1);
    chk("w1_latency", rsp_cyc - acc_cyc, 3);
    chk("w1_rsp", {l_rdata, l_resp, l_to}, {32'd0, 2'b00, 1'b0});
    chk("w1_wr_count", wr_count, 16'd1);

    // Read with delayed rvalid.
    set_dly(0, 0, 0, 0, 5); nx_rdata = 32'h12345678;
    send(0, 32'd11, 32'h0, 4'h0);
    recv(0);
    chk("r1_latency", rsp_cyc - acc_cyc, 8);
    chk("r1_rsp", {l_rdata, l_resp}, {32'h12345678, 2'b00});
    chk("r1_rd_count", rd_count, 16'd1);

    // awready immediately, wready after three waits.
    set_dly(0, 3, 0, 0, 0);
    b_aw = n_aw; b_w = n_w;
    send(1, 32'h40, 32'hA5A5_0001, 4'h3);
    recv(0);
    chk("w2_aw_cycles", n_aw - b_aw, 1);
    chk("w2_w_cycles", n_w - b_w, 4);
    chk("w2_wr_count", wr_count, 16'd2);

    // Response held off while a new command is offered.
    set_dly(0, 0, 0, 0, 0); nx_rdata = 32'hCAFE0020;
    send(0, 32'd20, 32'h0, 4'h0);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge axi_clk); seen = (rsp_valid === 1'b1);
      @(posedge axi_clk); #1;
    end
    if (!seen) note_fail("hold_rsp_wait");
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h80; cmd_wdata = 32'h0BAD_F00D; cmd_wstrb = 4'hC;
    b_aw = n_aw; b_ar = n_ar; b_cr = n_crdy;
    repeat (10) @(posedge axi_clk);
    #1;
    chk("hold_cmd_ready", n_crdy - b_cr, 0);
    chk("hold_axi_idle", (n_aw - b_aw) + (n_ar - b_ar), 0);
    chk("hold_rdata", rsp_rdata, 32'hCAFE0020);
    recv(0);
    send(1, 32'h80, 32'h0BAD_F00D, 4'hC);
    recv(0);
    chk("hold_counts", {wr_count, rd_count}, {16'd3, 16'd2});

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    set_dly(0, 0, 0, 1000, 0);
    b_ar = n_ar;
    send(0, 32'h99, 32'h0, 4'h0);
    recv(0);
    chk("to_ar_cycles", n_ar - b_ar, 16);
    chk("to_rsp", {l_rdata, l_resp, l_to}, {32'd0, 2'b11, 1'b1});
    chk("to_rd_count", rd_count, 16'd2);
    set_dly(0, 0, 0, 0, 0);
`endif

    // Reset pulsed while waiting for B.
    set_dly(0, 0, 20, 0, 0);
    send(1, 32'h10, 32'h1111_2222, 4'hF);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge axi_clk); seen = (m_bready === 1'b1);
    end
    if (!seen) note_fail("wb_wait");
    @(posedge axi_clk); #2;
    axi_rst = 1;
    #1;
    chk("arst_outs", {m_bready, rsp_valid, cmd_ready}, 0);
    chk("arst_wr_count", wr_count, 16'd0);
    repeat (2) @(posedge axi_clk);
    #2 axi_rst = 0;
    set_dly(0, 0, 0, 0, 0); nx_bresp = 2'b10;
    send(1, 32'h14, 32'h3333_4444, 4'h5);
    recv(0);
    chk("post_rst_rsp", {l_resp, l_to}, {2'b10, 1'b0});
    chk("post_rst_wr_count", wr_count, 16'd1);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      set_dly($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 4));
      nx_bresp = 2'($urandom); nx_rresp = 2'($urandom); nx_rdata = $urandom;
      send(1'($urandom), $urandom, $urandom, 4'($urandom));
      recv(1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge axi_clk);
      #1;
    end
    repeat (3) @(posedge axi_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : global_guard
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
